// File: rtl/demux_1to4_buffered_if.sv
// Bundle of every non-clock signal of the buffered 1-to-4 demultiplexer.
//
// Input side : x / x_valid / x_ready word handshake, s (explicit target), rr (round-robin
//              enable), route (channel the next accepted word will enter).
// Channels   : a..d head-of-FIFO data, *_valid (FIFO non-empty), *_ready (consumer pop),
//              *_cnt (fill level, 0..DEPTH).
//
// Modports   : slave  - the demultiplexer itself
//              master - the producer/consumer environment around it
interface demux_1to4_buffered_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] x;
  logic             x_valid;
  logic             x_ready;
  logic [1:0]       s;
  logic             rr;
  logic [1:0]       route;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             a_valid;
  logic             b_valid;
  logic             c_valid;
  logic             d_valid;
  logic             a_ready;
  logic             b_ready;
  logic             c_ready;
  logic             d_ready;
  logic [CntW-1:0]  a_cnt;
  logic [CntW-1:0]  b_cnt;
  logic [CntW-1:0]  c_cnt;
  logic [CntW-1:0]  d_cnt;

  modport slave (
    input  x, x_valid, s, rr,
    input  a_ready, b_ready, c_ready, d_ready,
    output x_ready, route,
    output a, b, c, d,
    output a_valid, b_valid, c_valid, d_valid,
    output a_cnt, b_cnt, c_cnt, d_cnt
  );

  modport master (
    output x, x_valid, s, rr,
    output a_ready, b_ready, c_ready, d_ready,
    input  x_ready, route,
    input  a, b, c, d,
    input  a_valid, b_valid, c_valid, d_valid,
    input  a_cnt, b_cnt, c_cnt, d_cnt
  );
endinterface

// File: rtl/demux_1to4_buffered.sv
// Buffered 1-to-4 demultiplexer.
//
// Each accepted input word is steered into one of four first-word-fall-through FIFOs
// (channel 0..3 = A..D), either to the channel named by s or, with rr=1, to successive
// channels in round-robin order. Every channel drains on its own valid/ready handshake,
// so a stalled consumer only blocks words addressed to its own channel.
//
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - demux_1to4_buffered_if.slave (input handshake, routing controls, four channels)
//
// Parameters:
//   WIDTH - data width
//   DEPTH - entries per channel FIFO (power of two, >= 2)
module demux_1to4_buffered #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input logic                    clk,
  input logic                    rst,
  demux_1to4_buffered_if.slave   bus
);
  localparam int unsigned NumCh = 4;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // Storage and per-channel state
  logic [WIDTH-1:0] mem_q [NumCh][DEPTH];
  logic [PtrW-1:0]  wr_ptr_q [NumCh];
  logic [PtrW-1:0]  wr_ptr_d [NumCh];
  logic [PtrW-1:0]  rd_ptr_q [NumCh];
  logic [PtrW-1:0]  rd_ptr_d [NumCh];
  logic [CntW-1:0]  cnt_q    [NumCh];
  logic [CntW-1:0]  cnt_d    [NumCh];
  logic [1:0]       rr_ptr_q;
  logic [1:0]       rr_ptr_d;

  // Decoded control
  logic [1:0]       route;
  logic             x_ready;
  logic             push;
  logic [NumCh-1:0] ch_ready;
  logic [NumCh-1:0] ch_valid;
  logic [NumCh-1:0] push_ch;
  logic [NumCh-1:0] pop_ch;

  assign ch_ready = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};

  // Routing and acceptance depend only on registered state plus s/rr. Acceptance looks at
  // the registered count, so a pop in the same cycle never frees room for this push and
  // there is no path from any *_ready to x_ready.
  assign route   = bus.rr ? rr_ptr_q : bus.s;
  assign x_ready = (cnt_q[route] != CntFull);
  assign push    = bus.x_valid && x_ready;

  always_comb begin
    push_ch  = '0;
    ch_valid = '0;
    pop_ch   = '0;
    for (int i = 0; i < NumCh; i++) begin
      push_ch[i]  = push && (route == 2'(i));
      ch_valid[i] = (cnt_q[i] != '0);
      // An empty channel ignores its ready input.
      pop_ch[i]   = ch_valid[i] && ch_ready[i];
    end
  end

  // Next-state for pointers and counts
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    // The round-robin pointer only moves on pushes made in round-robin mode, so
    // switching rr off and back on resumes where it left off.
    if (push && bus.rr) begin
      rr_ptr_d = rr_ptr_q + 2'd1;
    end
    for (int i = 0; i < NumCh; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      // Pointers are log2(DEPTH) bits wide, so the natural wrap is modulo DEPTH.
      if (push_ch[i]) begin
        wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(1);
      end
      if (pop_ch[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(1);
      end
      unique case ({push_ch[i], pop_ch[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // State registers; reset wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NumCh; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NumCh; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  // Storage is cleared on reset so the channel outputs read zero afterwards; once words
  // have drained an empty channel simply shows whatever was last written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumCh; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        if (push_ch[i]) begin
          mem_q[i][wr_ptr_q[i]] <= bus.x;
        end
      end
    end
  end

  // Outputs: first-word-fall-through head of each FIFO
  assign bus.x_ready = x_ready;
  assign bus.route   = route;

  assign bus.a = mem_q[0][rd_ptr_q[0]];
  assign bus.b = mem_q[1][rd_ptr_q[1]];
  assign bus.c = mem_q[2][rd_ptr_q[2]];
  assign bus.d = mem_q[3][rd_ptr_q[3]];

  assign bus.a_valid = ch_valid[0];
  assign bus.b_valid = ch_valid[1];
  assign bus.c_valid = ch_valid[2];
  assign bus.d_valid = ch_valid[3];

  assign bus.a_cnt = cnt_q[0];
  assign bus.b_cnt = cnt_q[1];
  assign bus.c_cnt = cnt_q[2];
  assign bus.d_cnt = cnt_q[3];
endmodule

// File: tb/tb_demux_1to4_buffered.sv
// Testbench for demux_1to4_buffered: directed pushes record the expected word in a
// per-channel queue; an independent monitor pops and compares whenever a channel
// hands a word to its consumer (valid && ready).
module tb_demux_1to4_buffered;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst;

  demux_1to4_buffered_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux_1to4_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] dat [4];
  logic [3:0] vld;
  logic [1:0] cnt [4];
  logic [3:0] rdy;

  assign dat[0] = bus.a;
  assign dat[1] = bus.b;
  assign dat[2] = bus.c;
  assign dat[3] = bus.d;
  assign vld    = {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};
  assign cnt[0] = bus.a_cnt;
  assign cnt[1] = bus.b_cnt;
  assign cnt[2] = bus.c_cnt;
  assign cnt[3] = bus.d_cnt;
  assign bus.a_ready = rdy[0];
  assign bus.b_ready = rdy[1];
  assign bus.c_ready = rdy[2];
  assign bus.d_ready = rdy[3];

  int total = 0;
  int bad   = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] q3 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic q_push(input int ch, input logic [7:0] d);
    case (ch)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic q_pop(input int ch, output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    case (ch)
      0: if (q0.size() > 0) begin d = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin d = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin d = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() > 0) begin d = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic q_flush();
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
  endtask

  // Monitor: every word a consumer takes must be the oldest expected word of its channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (vld[i] && rdy[i]) begin
          logic [7:0] e;
          bit ok;
          q_pop(i, e, ok);
          total++;
          if (!ok) begin
            bad++;
            $display("FAIL pop_unexpected ch%0d: got %0h want none", i, dat[i]);
          end else if (dat[i] !== e) begin
            bad++;
            $display("FAIL pop_ch%0d: got %0h want %0h (t=%0t)", i, dat[i], e, $time);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one cycle; exp_ch is the bench's own idea of the route.
  task automatic push(input logic [7:0] d, input int exp_ch, input bit exp_acc);
    bus.x       = d;
    bus.x_valid = 1'b1;
    @(negedge clk);
    chk($sformatf("x_ready@%0h", d), 32'(bus.x_ready), 32'(exp_acc));
    chk($sformatf("route@%0h", d), 32'(bus.route), 32'(exp_ch));
    if (exp_acc) q_push(exp_ch, d);
    cyc();
    bus.x_valid = 1'b0;
  endtask

  task automatic chk_all_empty(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(vld[i]), 32'd0);
      chk($sformatf("%s_cnt%0d", tag, i), 32'(cnt[i]), 32'd0);
    end
    chk($sformatf("%s_x_ready", tag), 32'(bus.x_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.x       = '0;
    bus.x_valid = 1'b0;
    bus.s       = 2'd0;
    bus.rr      = 1'b0;
    rdy         = 4'h0;
    rst         = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk_all_empty("rst");
    for (int i = 0; i < 4; i++) chk($sformatf("rst_data%0d", i), 32'(dat[i]), 32'd0);
    chk("rst_route_s0", 32'(bus.route), 32'd0);
    cyc();
    bus.s = 2'd3;
    #1;
    chk("route_follows_s", 32'(bus.route), 32'd3);

    // Single word by S=2 into C
    bus.s = 2'd2;
    push(8'h03, 2, 1'b1);
    @(negedge clk);
    chk("c_valid", 32'(vld[2]), 32'd1);
    chk("c_cnt", 32'(cnt[2]), 32'd1);
    chk("c_data", 32'(dat[2]), 32'h03);
    chk("abd_valid", 32'({vld[3], vld[1], vld[0]}), 32'd0);
    cyc();
    rdy[2] = 1'b1;
    cyc();
    rdy[2] = 1'b0;
    @(negedge clk);
    chk("c_drained", 32'(cnt[2]), 32'd0);
    cyc();

    // Round-robin, back-to-back, all consumers ready
    bus.rr = 1'b1;
    rdy    = 4'hF;
    for (int k = 0; k < 5; k++) push(8'(8'h10 + k), k % 4, 1'b1);
    cyc();
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_drained%0d", i), 32'(cnt[i]), 32'd0);
    cyc();
    rdy = 4'h0;

    // Backpressure on B
    bus.rr = 1'b0;
    bus.s  = 2'd1;
    push(8'hAA, 1, 1'b1);
    push(8'hBB, 1, 1'b1);
    @(negedge clk);
    chk("b_cnt_full", 32'(cnt[1]), 32'd2);
    cyc();
    bus.x       = 8'hCC;
    bus.x_valid = 1'b1;
    @(negedge clk);
    chk("b_full_refuse", 32'(bus.x_ready), 32'd0);
    cyc();
    rdy[1] = 1'b1;
    @(negedge clk);
    chk("pop_no_room", 32'(bus.x_ready), 32'd0);
    cyc();
    rdy[1] = 1'b0;
    @(negedge clk);
    chk("b_cnt_after_pop", 32'(cnt[1]), 32'd1);
    chk("b_room_again", 32'(bus.x_ready), 32'd1);
    q_push(1, 8'hCC);
    cyc();
    bus.x_valid = 1'b0;
    @(negedge clk);
    chk("b_cnt_refill", 32'(cnt[1]), 32'd2);
    chk("b_head_bb", 32'(dat[1]), 32'hBB);
    cyc();
    rdy[1] = 1'b1;
    cyc();
    cyc();
    rdy[1] = 1'b0;
    @(negedge clk);
    chk("b_drained", 32'(cnt[1]), 32'd0);
    cyc();

    // Round-robin pointer retained across an RR=0 push
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q_flush();
    bus.rr = 1'b1;
    push(8'h20, 0, 1'b1);
    push(8'h21, 1, 1'b1);
    bus.rr = 1'b0;
    bus.s  = 2'd0;
    push(8'h22, 0, 1'b1);
    bus.rr = 1'b1;
    push(8'h23, 2, 1'b1);
    @(negedge clk);
    chk("rr_a_cnt", 32'(cnt[0]), 32'd2);
    chk("rr_b_cnt", 32'(cnt[1]), 32'd1);
    chk("rr_c_cnt", 32'(cnt[2]), 32'd1);
    chk("rr_d_cnt", 32'(cnt[3]), 32'd0);
    chk("rr_a_head", 32'(dat[0]), 32'h20);
    cyc();
    push(8'h24, 3, 1'b1);
    @(negedge clk);
    chk("all_hold", 32'(vld), 32'hF);
    cyc();

    // Reset with words in every channel
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q_flush();
    @(negedge clk);
    chk_all_empty("rst2");
    chk("rst2_route_rr", 32'(bus.route), 32'd0);
    cyc();
    push(8'h30, 0, 1'b1);
    @(negedge clk);
    chk("post_rst_a", 32'(dat[0]), 32'h30);
    cyc();
    rdy = 4'hF;
    cyc();
    cyc();
    @(negedge clk);
    chk("left_q0", 32'(q0.size()), 32'd0);
    chk("left_q1", 32'(q1.size()), 32'd0);
    chk("left_q2", 32'(q2.size()), 32'd0);
    chk("left_q3", 32'(q3.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_1to4_buffered.md
# demux_1to4_buffered

Buffered 1-to-4 demultiplexer: the distribution side of the team's 4-to-1 mux datapath. It accepts a stream of WIDTH-bit words on one input and steers each word into one of four per-channel FIFOs, A/B/C/D. A word goes to the channel named by select input S, or to successive channels in round-robin order. Each channel drains independently through a valid/ready handshake, so a slow consumer stalls only traffic addressed to that channel.

## Interface
- WIDTH, 8, data width of input and every channel
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- X  input  WIDTH  input data word
- X_VALID  input  1  X holds a word
- X_READY  output  1  block accepts X this cycle
- S  input  2  explicit target channel (0=A, 1=B, 2=C, 3=D) when RR=0
- RR  input  1  1 = round-robin routing, 0 = routing by S
- ROUTE  output  2  channel the next accepted word will enter
- A, B, C, D  output  WIDTH each  head-of-FIFO data per channel
- A_VALID, B_VALID, C_VALID, D_VALID  output  1 each  channel FIFO non-empty
- A_READY, B_READY, C_READY, D_READY  input  1 each  consumer takes the head word
- A_CNT, B_CNT, C_CNT, D_CNT  output  $clog2(DEPTH)+1 each  channel fill level

## Operation
- Target selection:
  - ROUTE = RR ? rr_ptr : S. Purely combinational from registered rr_ptr, S and RR.
- Input acceptance:
  - X_READY = (CNT of channel ROUTE) != DEPTH. Computed from registered counts only.
  - A pop in the same cycle never makes room for a push to a full channel.
- Push:
  - A push occurs when X_VALID && X_READY.
  - X is written at that channel's write pointer, and the pointer increments modulo DEPTH.
- Round-robin pointer:
  - rr_ptr increments (3 wraps to 0) on each push while RR=1.
  - When RR=0, rr_ptr holds its value, so toggling RR resumes round-robin from the retained pointer.
- Pop:
  - Per channel, a pop occurs when *_VALID && *_READY.
  - The read pointer increments modulo DEPTH.
  - The FIFO is first-word-fall-through: the head word is presented on A..D whenever VALID=1.
- Count update per channel:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
  - Because of the acceptance rule, a count never exceeds DEPTH and never goes below 0.
- Empty channel:
  - *_VALID=0. The *_READY input is ignored.
  - The data output shows stale RAM contents, which benches must not check.
- Ordering: words within one channel leave in acceptance order. No ordering is defined across channels.
- S, RR and X are sampled only in a push cycle. Changing them while X_READY=0 causes no side effect.

## Timing
- Reset (RST=1 at a rising edge):
  - all counts 0, all read/write pointers 0, rr_ptr 0
  - A..D = 0, all *_VALID = 0, *_CNT = 0
  - ROUTE = S if RR=0, else 0
  - X_READY = 1 on the cycle after reset
- Reset has priority over any simultaneous push or pop. Words in flight are discarded. There is no partial-reset state.
- Latency: a word pushed at edge N appears on the channel output with VALID=1 after edge N, i.e. 1 cycle.
- Throughput: one push per cycle, plus one pop per channel per cycle, concurrently.
- With DEPTH=2 and a permanently ready consumer, a single channel sustains 1 word/cycle.
- X_READY, ROUTE and all *_VALID/*_CNT outputs are functions of registered state and S/RR only. There is no combinational path from any *_READY to X_READY.

## Test plan
- Reset, then RR=0, S=2, push X=0x03 -> next cycle C=0x03, C_VALID=1, C_CNT=1. A/B/D_VALID remain 0.
- RR=1, C/D/A/B_READY=1, push 0x10,0x11,0x12,0x13,0x14 back-to-back ->
  - words land in A,B,C,D,A
  - ROUTE sequence 0,1,2,3,0
  - X_READY stays 1 throughout
- RR=0, S=1, B_READY=0, push three words 0xAA,0xBB,0xCC ->
  - B_CNT=2 after the second word
  - X_READY=0 while 0xCC is presented
  - raise B_READY for one cycle: pop 0xAA, then 0xCC accepted the next cycle
  - B then outputs 0xBB, 0xCC in order
- B full (CNT=2), B_READY=1 and X_VALID=1 with S=1 in the same cycle -> pop happens, push is refused, B_CNT becomes 1.
- RR=1, push 2 words (rr_ptr=2), set RR=0 and push with S=0, then set RR=1 and push -> words go to A, B, A, then C.
- RST asserted with all channels holding words -> next cycle all VALID=0, CNT=0, ROUTE=0 (RR=1), X_READY=1. The first post-reset push lands in A.
